wb_frame_reader: RTL and testbench
==================================

# wb_frame_reader

Wishbone master that sits directly upstream of the Wishbone BlockRAM slave and streams a contiguous block of 32-bit words out of it. On a start pulse it issues classic single-word read cycles from a base address and pushes each returned word into an internal FIFO. A valid/ready stream drains the FIFO toward the pixel/consumer stage. The block throttles its bus requests so the FIFO never overflows.

## Interface
- BASE_ADR, 0: byte address of the first word read.
- NWORDS, 2048: number of words per transfer, at least 1.
- ADR_STEP, 4: address increment per word, in bytes.
- FIFO_DEPTH, 16: output FIFO depth in words, a power of two, at least 2.
- clk  in  1  single clock; wb_m.clk is driven from it.
- rst  in  1  synchronous, active-high reset; wb_m.rst is driven from it.
- wb_m  wshb_if.master  –  Wishbone master port: cyc, stb, we, sel, adr[31:0], dat_ms[31:0], dat_sm[31:0], ack.
- start  in  1  one-cycle request to begin a transfer.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse after the last word is accepted from the bus.
- dout  out  32  FIFO head word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  the consumer accepts dout this cycle.

## Operation
- FSM states: IDLE, READ, DONE.
- **IDLE**
  - busy=0.
  - On start: adr_r←BASE_ADR, remaining←NWORDS, go to READ.
- **READ**
  - busy=1, cyc=1, we=0, sel=4'b1111, adr=adr_r, dat_ms=0.
  - stb=1 iff the FIFO is not full (count≠FIFO_DEPTH). stb is a combinational function of the current state and count.
  - On ack with stb=1: push dat_sm, adr_r←adr_r+ADR_STEP with 32-bit wrap, remaining←remaining−1.
  - An ack that arrives while stb=0 is ignored.
  - When ack is seen with remaining=1: go to DONE.
- **DONE**
  - cyc=0, stb=0, done=1 for exactly one cycle, then go to IDLE.
  - The FIFO keeps draining independently of the FSM.
- start is ignored unless the FSM is in IDLE.
- The FIFO holds data across transfers; it is not flushed by start.
- Stream rules:
  - dout_valid=1 iff the FIFO is not empty.
  - A pop occurs iff dout_valid and dout_ready are both 1.
  - dout must stay stable while dout_valid=1 and dout_ready=0.
- Simultaneous push and pop when full: the pop frees a slot, but stb was already 0 that cycle, so no push occurs. stb rises on the next cycle.
- Simultaneous push and pop when empty is not possible, because dout_valid=0.
- remaining is $clog2(NWORDS+1) bits wide.

## Timing
- The slave may acknowledge in the same cycle as stb (combinational ack) or any number of cycles later.
  - The master holds adr and stb until ack.
  - Throughput is at most one word per clock.
- First stb is one cycle after the start cycle.
- A word pushed on cycle t appears on dout with dout_valid=1 at cycle t+1.
- done is asserted the cycle after the last ack.
- Reset values: cyc=0, stb=0, we=0, adr=BASE_ADR, busy=0, done=0, dout_valid=0; the FIFO is empty and the FSM is in IDLE.
- Reset mid-transfer:
  - cyc and stb are 0 from the first cycle after the reset edge.
  - FIFO contents are discarded.
  - An ack that arrives during or after reset is ignored.

## Structure
- Package wb_frame_reader_pkg holds:
  - the state enum typedef state_t {IDLE, READ, DONE};
  - the constant WORD_W=32.
- Sub-module sync_fifo (WIDTH, DEPTH):
  - ports: clk, rst, push, din, pop, dout, empty, full, count;
  - registered pointers, with one extra wrap bit for full/empty detection;
  - first-word-fall-through output.
- Top level: the FSM, address and remaining counters, and the Wishbone drive logic.

## Test plan
- **Basic transfer.** BRAM model preloaded with mem[i]=i; NWORDS=8, start, dout_ready=1 → dout sequence 0..7; adr steps 0,4,…,28; done pulses once; busy falls with done.
- **Back-pressure.** dout_ready=0, NWORDS=32, FIFO_DEPTH=16 → exactly 16 acks, then stb=0 with cyc=1. Raise dout_ready → the remaining 16 words arrive; no loss or duplication.
- **Slow slave.** Ack delayed 3 cycles → adr and stb stable until ack; one push per ack; an extra ack while stb=0 is ignored.
- **Start while busy.** Second start pulse mid-transfer → ignored; total words equal NWORDS; one done pulse.
- **Reset mid-transfer.** rst after 5 of 8 words → next cycle cyc=0, stb=0, dout_valid=0, busy=0. A new start then reads from BASE_ADR again.
- **Address wrap.** BASE_ADR=32'hFFFF_FFF8, NWORDS=4 → adr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.

Source files
------------

// File: rtl/wb_frame_reader_pkg.sv
// Shared types and constants for the Wishbone frame reader.
package wb_frame_reader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; the master also forwards clock and reset to the slave.
interface wshb_if;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;

    modport master (
        output clk, rst, cyc, stb, we, sel, adr, dat_ms,
        input  dat_sm, ack
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, dat_ms,
        output dat_sm, ack
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers are equal when empty; they differ only in the wrap bit when full.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values for accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless outside the pointer window, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone master streaming NWORDS consecutive words into a FIFO drained by a valid/ready port.
module wb_frame_reader
    import wb_frame_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          NWORDS     = 2048,
    parameter logic [31:0] ADR_STEP   = 32'd4,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    wshb_if.master            wb_m,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam int REM_W = $clog2(NWORDS + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [REM_W-1:0] REM_ONE = {{(REM_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [31:0]        adr_q, adr_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               cyc_q, cyc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               stb;
    logic               push;
    logic               fifo_empty;
    logic               fifo_full_unused;
    logic [CNT_W-1:0]   fifo_count;

    // Request only while a slot is free, so an acknowledged word always fits.
    assign stb  = (state_q == READ) && (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push = stb && wb_m.ack;

    assign wb_m.clk    = clk;
    assign wb_m.rst    = rst;
    assign wb_m.cyc    = cyc_q;
    assign wb_m.stb    = stb;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'b1111;
    assign wb_m.adr    = adr_q;
    assign wb_m.dat_ms = '0;

    assign busy       = busy_q;
    assign done       = done_q;
    assign dout_valid = !fifo_empty;

    // The full flag is implied by the count comparison above; only count drives stb.
    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wb_m.dat_sm),
        .pop   (dout_valid && dout_ready),
        .dout  (dout),
        .empty (fifo_empty),
        .full  (fifo_full_unused),
        .count (fifo_count)
    );

    // Next-state, address/remaining counters and registered bus/status outputs.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    adr_d   = BASE_ADR;
                    rem_d   = REM_W'(NWORDS);
                end
            end
            READ: begin
                if (push) begin
                    adr_d = adr_q + ADR_STEP;
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cyc_d  = (state_d == READ);
        busy_d = (state_d == READ);
        done_d = (state_d == DONE);
    end

    // FSM and counter registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= BASE_ADR;
            rem_q   <= '0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_wb_frame_reader.sv
// Randomized bench for wb_frame_reader with a queue-based reference model.
module tb_wb_frame_reader;

    localparam logic [31:0] BASE  = 32'hFFFF_FFF0;
    localparam int          NW    = 24;
    localparam int          DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    wshb_if wb();

    wb_frame_reader #(
        .BASE_ADR   (BASE),
        .NWORDS     (NW),
        .ADR_STEP   (32'd4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_m       (wb),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    // BRAM slave contents and ack behaviour
    logic [31:0] mem [256];
    logic [1:0]  ack_mode;   // 0 random, 1 same-cycle, 2 after three wait cycles
    logic [1:0]  rdy_mode;   // 0 stalled, 1 always ready, 2 random
    logic        ack_rnd;
    logic        spur;
    int          wait_cnt;

    assign wb.dat_sm = mem[wb.adr[9:2]];
    assign wb.ack    = wb.stb ? ((ack_mode == 2'd0) ? ack_rnd :
                                 (ack_mode == 2'd1) ? 1'b1 : (wait_cnt >= 3))
                              : spur;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (wb.stb && !wb.ack) wait_cnt <= wait_cnt + 1;
        else                   wait_cnt <= 0;
    end

    always @(posedge clk) begin
        #1;
        ack_rnd    = 1'($urandom_range(0, 1));
        spur       = ($urandom_range(0, 3) == 0);
        dout_ready = (rdy_mode == 2'd2) ? 1'($urandom_range(0, 1)) : rdy_mode[0];
    end

    // Scoreboard counters
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait expired at %0t", nm, $time);
    endtask

    // Reference model: transfer in progress, words acked, done cycle, FIFO contents
    bit          checks_on = 1'b0;
    bit          m_active  = 1'b0;
    bit          m_done    = 1'b0;
    bit          nd, do_push, do_pop;
    int          m_k       = 0;
    int          xfer_acks = 0;
    int          done_seen = 0;
    int          pops      = 0;
    logic [31:0] a;
    logic [31:0] q[$];
    logic [31:0] adr_log[$];

    always @(negedge clk) begin
        if (checks_on) begin
            chk("cyc", 32'(wb.cyc), 32'(m_active));
            chk("stb", 32'(wb.stb), 32'(m_active && (q.size() < DEPTH)));
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("dout_valid", 32'(dout_valid), 32'(q.size() != 0));
            chk("wb_rst", 32'(wb.rst), 32'(rst));
            if (q.size() != 0) chk("dout", dout, q[0]);
            if (m_active) begin
                chk("adr", wb.adr, BASE + 32'(m_k) * 32'd4);
                chk("we", 32'(wb.we), 32'd0);
                chk("sel", 32'(wb.sel), 32'hF);
                chk("dat_ms", wb.dat_ms, 32'd0);
            end
            if (done === 1'b1) done_seen++;
        end
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
            q.delete();
        end else begin
            nd      = 1'b0;
            do_push = m_active && (q.size() < DEPTH) && (wb.ack === 1'b1);
            do_pop  = (q.size() != 0) && (dout_ready === 1'b1);
            if (do_pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (do_push) begin
                a = BASE + 32'(m_k) * 32'd4;
                q.push_back(mem[a[9:2]]);
                adr_log.push_back(wb.adr);
                m_k++;
                xfer_acks++;
                if (m_k == NW) begin
                    m_active = 1'b0;
                    nd       = 1'b1;
                end
            end else if (!m_active && !m_done && (start === 1'b1)) begin
                m_active  = 1'b1;
                m_k       = 0;
                xfer_acks = 0;
                adr_log.delete();
            end
            m_done = nd;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_seen < target) timeout("wait_done");
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (dout_valid !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dout_valid !== 1'b0) timeout("wait_drain");
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (xfer_acks < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (xfer_acks < target) timeout("wait_acks");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rdy_mode = 2'd1;
        ack_mode = 2'd0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks_on = 1'b1;
        @(negedge clk);
        chk("rst_cyc", 32'(wb.cyc), 32'd0);
        chk("rst_stb", 32'(wb.stb), 32'd0);
        chk("rst_we", 32'(wb.we), 32'd0);
        chk("rst_adr", wb.adr, 32'hFFFF_FFF0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);

        // Basic transfer with random acks, plus a second start while busy
        pulse_start();
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1, 2000);
        wait_drain(200);
        repeat (10) @(negedge clk);
        chk("t1_done_count", 32'(done_seen), 32'd1);
        chk("t1_pops", 32'(pops), 32'd24);
        chk("t1_nacks", 32'(adr_log.size()), 32'd24);
        chk("t1_adr0", adr_log[0], 32'hFFFF_FFF0);
        chk("t1_adr3", adr_log[3], 32'hFFFF_FFFC);
        chk("t1_adr4_wrap", adr_log[4], 32'h0000_0000);
        chk("t1_adr5", adr_log[5], 32'h0000_0004);

        // Back-pressure: consumer stalled, fast slave
        @(posedge clk); #1;
        rdy_mode = 2'd0;
        ack_mode = 2'd1;
        pulse_start();
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("bp_acks", 32'(xfer_acks), 32'd16);
        chk("bp_cyc", 32'(wb.cyc), 32'd1);
        chk("bp_stb", 32'(wb.stb), 32'd0);
        chk("bp_valid", 32'(dout_valid), 32'd1);
        @(posedge clk); #1 rdy_mode = 2'd1;
        wait_done(2, 2000);
        wait_drain(200);
        chk("bp_pops", 32'(pops), 32'd48);
        chk("bp_done_count", 32'(done_seen), 32'd2);

        // Slow slave with random consumer
        @(posedge clk); #1;
        rdy_mode = 2'd2;
        ack_mode = 2'd2;
        pulse_start();
        wait_done(3, 3000);
        wait_drain(400);
        chk("slow_pops", 32'(pops), 32'd72);
        chk("slow_nacks", 32'(adr_log.size()), 32'd24);

        // Reset after five words, then a fresh transfer from the base address
        @(posedge clk); #1;
        rdy_mode = 2'd0;
        ack_mode = 2'd0;
        pulse_start();
        wait_acks(5, 500);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_cyc", 32'(wb.cyc), 32'd0);
        chk("mid_rst_stb", 32'(wb.stb), 32'd0);
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rdy_mode = 2'd1;
        pulse_start();
        wait_done(4, 2000);
        wait_drain(200);
        chk("rst_restart_adr0", adr_log[0], 32'hFFFF_FFF0);
        chk("rst_restart_nacks", 32'(adr_log.size()), 32'd24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
